// File: rtl/dec2bin_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package dec2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } dec2bin_state_e;

    localparam int BCD_MAX = 9;

    // x*10 as two shifts and an add, so no multiplier is inferred.
    function automatic logic [31:0] mul10(input logic [31:0] a);
        return (a << 3) + (a << 1);
    endfunction

endpackage

// File: rtl/dec2bin_seq_bcd_mac_step.sv
// One multiply-accumulate step acc*10 + digit, with saturation at 2**BIN_W-1
// and out-of-range digits clamped to 9.
module bcd_mac_step
    import dec2bin_pkg::*;
#(
    parameter int DIG_W = 8,
    parameter int BIN_W = 8
) (
    input  logic [BIN_W+3:0] acc,
    input  logic [DIG_W-1:0] digit,
    output logic [BIN_W+3:0] acc_next,
    output logic             ovf_step,
    output logic             bad_step
);
    localparam int          AW    = BIN_W + 4;
    localparam logic [31:0] MAX32 = (32'd1 << BIN_W) - 32'd1;

    logic [31:0] dig_c;
    logic [31:0] sum;

    always_comb begin
        bad_step = 32'(digit) > 32'(BCD_MAX);
        dig_c    = bad_step ? 32'(BCD_MAX) : 32'(digit);
        sum      = mul10(32'(acc)) + dig_c;
        ovf_step = sum > MAX32;
        acc_next = ovf_step ? AW'(MAX32) : AW'(sum);
    end

endmodule

// File: rtl/dec2bin_seq.sv
// Sequential BCD-to-binary converter, most-significant digit first, valid/ready on both sides.
// Optional DEC2BIN_LZ_SKIP_EN: start at the highest nonzero digit to shorten latency.
//
// state | meaning
// IDLE  | ready_o high, waiting for a digit set
// ACC   | one digit folded into the accumulator per clock
// DONE  | valid_o high, result held until ready_i
module dec2bin_seq
    import dec2bin_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int DIG_W = 8,
    parameter int BIN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DIG_W-1:0] dec_i [NDIG-1:0],
    output logic [BIN_W-1:0] bin_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             ovf_o,
    output logic             bad_o
);
    localparam int               AW      = BIN_W + 4;
    localparam int               IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]    IDX_TOP = IW'(NDIG - 1);
    localparam logic [BIN_W-1:0] MAX     = '1;

    dec2bin_state_e   state;
    logic [AW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    start_idx;
    logic [DIG_W-1:0] dig_q [NDIG-1:0];
    logic             ovf_acc, bad_acc;
    logic [AW-1:0]    acc_next;
    logic             ovf_step, bad_step;
    logic             ovf_fin, bad_fin;

    always_comb begin
`ifdef DEC2BIN_LZ_SKIP_EN
        start_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dec_i[i] != '0) start_idx = IW'(i);
        end
`else
        start_idx = IDX_TOP;
`endif
    end

    bcd_mac_step #(
        .DIG_W (DIG_W),
        .BIN_W (BIN_W)
    ) u_step (
        .acc      (acc),
        .digit    (dig_q[idx]),
        .acc_next (acc_next),
        .ovf_step (ovf_step),
        .bad_step (bad_step)
    );

    assign ovf_fin = ovf_acc | ovf_step;
    assign bad_fin = bad_acc | bad_step;
    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= IDX_TOP;
            ovf_acc <= 1'b0;
            bad_acc <= 1'b0;
            bin_o   <= '0;
            ovf_o   <= 1'b0;
            bad_o   <= 1'b0;
            for (int i = 0; i < NDIG; i++) dig_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        for (int i = 0; i < NDIG; i++) dig_q[i] <= dec_i[i];
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        bad_acc <= 1'b0;
                        idx     <= start_idx;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    acc     <= acc_next;
                    ovf_acc <= ovf_fin;
                    bad_acc <= bad_fin;
                    if (idx == '0) begin
                        // Published outputs change only here so they stay put in IDLE/ACC.
                        ovf_o <= ovf_fin;
                        bad_o <= bad_fin;
                        if (bad_fin)      bin_o <= '0;
                        else if (ovf_fin) bin_o <= MAX;
                        else              bin_o <= acc_next[BIN_W-1:0];
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
